// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes (also used by ControlUnit), fetch FSM encoding, reset PC.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_VALID = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction
endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection: jump target, branch target or sequential PC+4 (jump has priority).
module next_pc_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic [ADDR_WIDTH-1:0] sign_imm,
  input  logic [25:0]           jidx,
  input  logic                  pc_src,
  input  logic                  jmp,
  output logic [ADDR_WIDTH-1:0] next_pc
);
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] j_target;

  // Both targets wrap naturally modulo 2^ADDR_WIDTH.
  assign br_target = pc_plus4 + (sign_imm << 2);
  assign j_target  = {pc_plus4[ADDR_WIDTH-1:28], jidx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jmp)         next_pc = j_target;
    else if (pc_src) next_pc = br_target;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack FSM with timeout retry, retire counter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    TIMEOUT     = 15,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   ImemReq,
  output logic [ADDR_WIDTH-1:0]  ImemAddr,
  input  logic                   ImemAck,
  input  logic [INSTR_WIDTH-1:0] ImemRdata,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic [ADDR_WIDTH-1:0]  PCPlus4,
  input  logic                   Stall,
  input  logic                   PCSrc,
  input  logic                   Jmp,
  input  logic [ADDR_WIDTH-1:0]  SignImm,
  output logic                   FetchErr,
  output logic [CNT_WIDTH-1:0]   RetireCount
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_e          state, state_n;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [TW-1:0]         tcnt;
  logic                  consume;
  logic                  timeout;

  assign PC       = pc;
  assign ImemAddr = pc;
  assign PCPlus4  = pc + ADDR_WIDTH'(4);
  assign consume  = InstrValid & ~Stall;
  // An ack in the last allowed cycle takes priority over the timeout.
  assign timeout  = ImemReq & ~ImemAck & (tcnt == TW'(TIMEOUT - 1));

  next_pc_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc (
    .pc_plus4 (PCPlus4),
    .sign_imm (SignImm),
    .jidx     (Instruction[25:0]),
    .pc_src   (PCSrc),
    .jmp      (Jmp),
    .next_pc  (next_pc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= F_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      F_IDLE:  state_n = F_REQ;
      F_REQ:   if (ImemAck) state_n = F_VALID;
               else if (timeout) state_n = F_IDLE;
      F_VALID: if (consume) state_n = F_REQ;
      default: state_n = F_IDLE;
    endcase
  end

  always_comb begin
    ImemReq    = (state == F_REQ);
    InstrValid = (state == F_VALID);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc          <= RESET_PC;
      Instruction <= '0;
      tcnt        <= '0;
      FetchErr    <= 1'b0;
      RetireCount <= '0;
    end else begin
      FetchErr <= timeout;
      if (ImemReq) begin
        if (ImemAck) begin
          Instruction <= ImemRdata;
          tcnt        <= '0;
        end else if (timeout) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
      if (consume) begin
        pc          <= next_pc;
        RetireCount <= RetireCount + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, branch, jump, stall, timeout retry, async reset/wrap.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jmp = 1'b0;
  logic [31:0] SignImm = '0;
  logic        FetchErr;
  logic [31:0] RetireCount;

  int total = 0;
  int bad = 0;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
    .ImemRdata(ImemRdata), .Instruction(Instruction), .InstrValid(InstrValid), .PC(PC),
    .PCPlus4(PCPlus4), .Stall(Stall), .PCSrc(PCSrc), .Jmp(Jmp), .SignImm(SignImm),
    .FetchErr(FetchErr), .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  // Called at a negedge while in REQ; returns at the negedge of the VALID cycle.
  task automatic serve(input logic [31:0] w);
    ImemAck = 1'b1; ImemRdata = w;
    @(negedge CLK);
    ImemAck = 1'b0; ImemRdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", ImemReq); end
    total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", InstrValid); end
    total++; if (Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", Instruction); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
    total++; if (FetchErr !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", FetchErr); end
    total++; if (RetireCount !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", RetireCount); end
    RST = 1'b1;
    @(negedge CLK);
    total++; if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", ImemReq, ImemAddr); end
    serve(32'h2008_0005);
    total++; if ({InstrValid, ImemReq} !== 2'b10) begin bad++; $display("FAIL first_valid got=%b%b exp=10", InstrValid, ImemReq); end
    total++; if (Instruction !== 32'h2008_0005) begin bad++; $display("FAIL first_instr got=%h exp=20080005", Instruction); end
    total++; if (PCPlus4 !== 32'h4) begin bad++; $display("FAIL first_pcp4 got=%h exp=4", PCPlus4); end
    @(negedge CLK);
    total++; if ({ImemReq, InstrValid, ImemAddr} !== {2'b10, 32'h4}) begin bad++; $display("FAIL second_req got=%b%b/%h exp=10/4", ImemReq, InstrValid, ImemAddr); end
    total++; if (RetireCount !== 32'd1) begin bad++; $display("FAIL retire1 got=%0d exp=1", RetireCount); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin serve(32'h0); @(negedge CLK); end
    serve(32'h1000_FFFE);
    total++; if (PC !== 32'h10) begin bad++; $display("FAIL br_pc got=%h exp=10", PC); end
    PCSrc = 1'b1; SignImm = 32'hFFFF_FFFE;
    @(negedge CLK);
    PCSrc = 1'b0; SignImm = '0;
    total++; if (ImemAddr !== 32'h0C) begin bad++; $display("FAIL br_back got=%h exp=0c", ImemAddr); end
    total++; if (RetireCount !== 32'd5) begin bad++; $display("FAIL br_cnt got=%0d exp=5", RetireCount); end
    serve(32'h0); @(negedge CLK);
    serve(32'h1000_0003);
    PCSrc = 1'b1; SignImm = 32'h3;
    @(negedge CLK);
    PCSrc = 1'b0; SignImm = '0;
    total++; if (ImemAddr !== 32'h20) begin bad++; $display("FAIL br_fwd got=%h exp=20", ImemAddr); end
  endtask

  task automatic test_jump();
    serve(32'h0);
    PCSrc = 1'b1; SignImm = 32'h0FFF_FFF7;
    @(negedge CLK);
    PCSrc = 1'b0; SignImm = '0;
    total++; if (ImemAddr !== 32'h4000_0000) begin bad++; $display("FAIL j_setup got=%h exp=40000000", ImemAddr); end
    serve(32'h0800_0040);
    total++; if (PCPlus4 !== 32'h4000_0004) begin bad++; $display("FAIL j_pcp4 got=%h exp=40000004", PCPlus4); end
    Jmp = 1'b1; PCSrc = 1'b1; SignImm = 32'h5;
    @(negedge CLK);
    Jmp = 1'b0; PCSrc = 1'b0; SignImm = '0;
    total++; if (ImemAddr !== 32'h4000_0100) begin bad++; $display("FAIL j_target got=%h exp=40000100", ImemAddr); end
    total++; if (RetireCount !== 32'd9) begin bad++; $display("FAIL j_cnt got=%0d exp=9", RetireCount); end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    serve(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({Instruction, PC, RetireCount, ImemReq, InstrValid} !== {32'h1234_5678, 32'h4000_0100, 32'd9, 2'b01}) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%h/%0d/%b%b exp=12345678/40000100/9/01", i, Instruction, PC, RetireCount, ImemReq, InstrValid);
      end
      ImemAck = 1'b1; ImemRdata = 32'hDEAD_BEEF; PCSrc = 1'b1; SignImm = 32'h40;
      @(negedge CLK);
    end
    ImemAck = 1'b0; ImemRdata = '0; PCSrc = 1'b0; SignImm = '0; Stall = 1'b0;
    @(negedge CLK);
    total++; if ({ImemReq, ImemAddr} !== {1'b1, 32'h4000_0104}) begin bad++; $display("FAIL stall_release got=%b/%h exp=1/40000104", ImemReq, ImemAddr); end
    total++; if (RetireCount !== 32'd10) begin bad++; $display("FAIL stall_cnt got=%0d exp=10", RetireCount); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({ImemReq, FetchErr, ImemAddr} !== {2'b10, 32'h4000_0104}) begin
        bad++; $display("FAIL to_wait%0d got=%b%b/%h exp=10/40000104", i, ImemReq, FetchErr, ImemAddr);
      end
      @(negedge CLK);
    end
    total++; if ({ImemReq, FetchErr} !== 2'b01) begin bad++; $display("FAIL to_pulse got=%b%b exp=01", ImemReq, FetchErr); end
    @(negedge CLK);
    total++; if ({ImemReq, FetchErr, ImemAddr} !== {2'b10, 32'h4000_0104}) begin bad++; $display("FAIL to_retry got=%b%b/%h exp=10/40000104", ImemReq, FetchErr, ImemAddr); end
    repeat (14) @(negedge CLK);
    total++; if ({ImemReq, FetchErr} !== 2'b10) begin bad++; $display("FAIL to_last got=%b%b exp=10", ImemReq, FetchErr); end
    serve(32'hABCD_0001);
    total++; if ({FetchErr, InstrValid} !== 2'b01) begin bad++; $display("FAIL to_ackwins got=%b%b exp=01", FetchErr, InstrValid); end
    total++; if (Instruction !== 32'hABCD_0001) begin bad++; $display("FAIL to_instr got=%h exp=abcd0001", Instruction); end
  endtask

  task automatic test_reset_wrap();
    @(negedge CLK);
    total++; if (ImemAddr !== 32'h4000_0108) begin bad++; $display("FAIL mid_addr got=%h exp=40000108", ImemAddr); end
    ImemAck = 1'b1; ImemRdata = 32'h0000_0055;
    #2 RST = 1'b0;
    #1;
    total++;
    if ({ImemReq, InstrValid, FetchErr, PC, Instruction, RetireCount} !== {3'b000, 32'h0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL mid_rst got=%b%b%b/%h/%h/%0d exp=000/0/0/0", ImemReq, InstrValid, FetchErr, PC, Instruction, RetireCount);
    end
    @(negedge CLK);
    total++; if ({ImemReq, InstrValid} !== 2'b00) begin bad++; $display("FAIL mid_hold got=%b%b exp=00", ImemReq, InstrValid); end
    ImemAck = 1'b0; ImemRdata = '0; RST = 1'b1;
    @(negedge CLK);
    serve(32'h0);
    PCSrc = 1'b1; SignImm = 32'hFFFF_FFFE;
    @(negedge CLK);
    PCSrc = 1'b0; SignImm = '0;
    total++; if (ImemAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", ImemAddr); end
    serve(32'h0);
    total++; if (PCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_pcp4 got=%h exp=0", PCPlus4); end
    @(negedge CLK);
    total++; if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/0", ImemReq, ImemAddr); end
    total++; if (RetireCount !== 32'd2) begin bad++; $display("FAIL wrap_cnt got=%0d exp=2", RetireCount); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_timeout();
    test_reset_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
